// File: rtl/tradeoff_bist_driver.sv
// tradeoff_bist_driver
//   Self-test sequencer for a Tradeoff search core. It sits on the core's
//   W/found/N interface, accepts a stream of W patterns and drives each one
//   onto the core. After `found` it compares N against EXP_N and keeps
//   pass/fail counters.
//
// Optional feature macro: TRADEOFF_BIST_WATCHDOG_EN
//   Adds parameter TIMEOUT_CYCLES and output timeout_count. A pattern whose
//   `found` never arrives is failed after TIMEOUT_CYCLES cycles in WAIT_FOUND.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start               clears counters and begins a run (IDLE/DONE only)
//   pat_valid/data/last pattern stream; pat_ready is high only in LOAD
//   W                   pattern driven to the core, held until CHECK completes
//   found, N            core completion flag and result
//   busy, done          run in progress / run finished until next start
//   fail_pulse          one-cycle pulse on each failed pattern
//   total_count         patterns checked (saturating)
//   error_count         failed patterns (saturating)
//   last_fail_w         W of the most recent failure
//   timeout_count       watchdog expiries (watchdog build only)
module tradeoff_bist_driver #(
    parameter int unsigned W_BITS        = 46,
    parameter int unsigned N_BITS        = 31,
    parameter int unsigned EXP_N         = 1073741813,
    parameter int unsigned ARM_CYCLES    = 2,
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned CNT_W         = 16
`ifdef TRADEOFF_BIST_WATCHDOG_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 1048576
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              pat_valid,
    input  logic [W_BITS-1:0] pat_data,
    input  logic              pat_last,
    output logic              pat_ready,
    output logic [W_BITS-1:0] W,
    input  logic              found,
    input  logic [N_BITS-1:0] N,
    output logic              busy,
    output logic              done,
    output logic              fail_pulse,
    output logic [CNT_W-1:0]  total_count,
    output logic [CNT_W-1:0]  error_count,
    output logic [W_BITS-1:0] last_fail_w
`ifdef TRADEOFF_BIST_WATCHDOG_EN
    ,
    output logic [CNT_W-1:0]  timeout_count
`endif
);

    // Shared down-counter for the ARM and SETTLE phases.
    localparam int unsigned PH_MAX = (ARM_CYCLES > SETTLE_CYCLES) ? ARM_CYCLES : SETTLE_CYCLES;
    localparam int unsigned PH_W   = (PH_MAX < 2) ? 1 : $clog2(PH_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ARM,
        S_WAIT_FOUND,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [W_BITS-1:0]   w_q, w_d;
    logic                last_q, last_d;
    logic [PH_W-1:0]     ph_q, ph_d;
    logic [CNT_W-1:0]    total_q, total_d;
    logic [CNT_W-1:0]    err_q, err_d;
    logic [W_BITS-1:0]   lfw_q, lfw_d;
    logic                mismatch;
    logic                timeout_hit;

`ifdef TRADEOFF_BIST_WATCHDOG_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0]     wd_q, wd_d;
    logic [CNT_W-1:0]    tmo_q, tmo_d;
`endif

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    // Failure events of the current cycle.
    always_comb begin
        // Both sides zero-extended so every bit of N takes part in the compare.
        mismatch    = (state_q == S_CHECK) &&
                      ((N_BITS + 32)'(N) != (N_BITS + 32)'(EXP_N));
        timeout_hit = 1'b0;
`ifdef TRADEOFF_BIST_WATCHDOG_EN
        // A `found` arriving on the expiry cycle still wins.
        timeout_hit = (state_q == S_WAIT_FOUND) && !found &&
                      (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
`endif
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            w_q     <= '0;
            last_q  <= 1'b0;
            ph_q    <= '0;
            total_q <= '0;
            err_q   <= '0;
            lfw_q   <= '0;
`ifdef TRADEOFF_BIST_WATCHDOG_EN
            wd_q    <= '0;
            tmo_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            last_q  <= last_d;
            ph_q    <= ph_d;
            total_q <= total_d;
            err_q   <= err_d;
            lfw_q   <= lfw_d;
`ifdef TRADEOFF_BIST_WATCHDOG_EN
            wd_q    <= wd_d;
            tmo_q   <= tmo_d;
`endif
        end
    end

    // Next-state and datapath.
    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        last_d  = last_q;
        ph_d    = ph_q;
        total_d = total_q;
        err_d   = err_q;
        lfw_d   = lfw_q;
`ifdef TRADEOFF_BIST_WATCHDOG_EN
        wd_d    = '0;
        tmo_d   = tmo_q;
`endif
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    total_d = '0;
                    err_d   = '0;
`ifdef TRADEOFF_BIST_WATCHDOG_EN
                    tmo_d   = '0;
`endif
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (pat_valid) begin
                    w_d     = pat_data;
                    last_d  = pat_last;
                    ph_d    = PH_W'(ARM_CYCLES);
                    state_d = S_ARM;
                end
            end
            // Phase counters leave when the decremented value reaches zero,
            // so a phase of K cycles spends K cycles here (at least one).
            S_ARM: begin
                ph_d = (ph_q == '0) ? '0 : ph_q - 1'b1;
                if (ph_q <= PH_W'(1)) begin
                    state_d = S_WAIT_FOUND;
                end
            end
            S_WAIT_FOUND: begin
                if (found) begin
                    ph_d    = PH_W'(SETTLE_CYCLES);
                    state_d = S_SETTLE;
                end
`ifdef TRADEOFF_BIST_WATCHDOG_EN
                else if (timeout_hit) begin
                    total_d = sat_inc(total_q);
                    err_d   = sat_inc(err_q);
                    tmo_d   = sat_inc(tmo_q);
                    lfw_d   = w_q;
                    state_d = last_q ? S_DONE : S_LOAD;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
`endif
            end
            S_SETTLE: begin
                ph_d = (ph_q == '0) ? '0 : ph_q - 1'b1;
                if (ph_q <= PH_W'(1)) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                total_d = sat_inc(total_q);
                if (mismatch) begin
                    err_d = sat_inc(err_q);
                    lfw_d = w_q;
                end
                state_d = last_q ? S_DONE : S_LOAD;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs.
    always_comb begin
        pat_ready  = (state_q == S_LOAD);
        busy       = (state_q != S_IDLE) && (state_q != S_DONE);
        done       = (state_q == S_DONE);
        fail_pulse = mismatch || timeout_hit;
    end

    assign W           = w_q;
    assign total_count = total_q;
    assign error_count = err_q;
    assign last_fail_w = lfw_q;
`ifdef TRADEOFF_BIST_WATCHDOG_EN
    assign timeout_count = tmo_q;
`endif

endmodule

// File: tb/tb_tradeoff_bist_driver.sv
module tb_tradeoff_bist_driver;

    localparam int unsigned W_BITS   = 46;
    localparam int unsigned N_BITS   = 31;
    localparam int unsigned EXP_N    = 1073741813;
    localparam int          ARM      = 2;
    localparam int          SETTLE   = 1;
    localparam int          TIMEOUT  = 64;
    // Cycles spent in each counted phase: a zero count still costs one cycle.
    localparam int          ARM_EFF  = (ARM < 1) ? 1 : ARM;
    localparam int          SET_EFF  = (SETTLE < 1) ? 1 : SETTLE;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              pat_valid = 1'b0;
    logic [W_BITS-1:0] pat_data = '0;
    logic              pat_last = 1'b0;
    logic              pat_ready;
    logic [W_BITS-1:0] W;
    logic              found = 1'b0;
    logic [N_BITS-1:0] N = '0;
    logic              busy, done, fail_pulse;
    logic [15:0]       total_count, error_count;
    logic [W_BITS-1:0] last_fail_w;
`ifdef TRADEOFF_BIST_WATCHDOG_EN
    logic [15:0]       timeout_count;
`endif

    int tests = 0;
    int fails = 0;

    // Reference model state.
    int                exp_total, exp_err, exp_tmo;
    logic [W_BITS-1:0] exp_w, exp_lfw;

    always #5 clk = ~clk;

    tradeoff_bist_driver #(
        .W_BITS(W_BITS), .N_BITS(N_BITS), .EXP_N(EXP_N),
        .ARM_CYCLES(ARM), .SETTLE_CYCLES(SETTLE), .CNT_W(16)
`ifdef TRADEOFF_BIST_WATCHDOG_EN
        , .TIMEOUT_CYCLES(TIMEOUT)
`endif
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .pat_valid(pat_valid), .pat_data(pat_data), .pat_last(pat_last),
        .pat_ready(pat_ready), .W(W), .found(found), .N(N),
        .busy(busy), .done(done), .fail_pulse(fail_pulse),
        .total_count(total_count), .error_count(error_count),
        .last_fail_w(last_fail_w)
`ifdef TRADEOFF_BIST_WATCHDOG_EN
        , .timeout_count(timeout_count)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_W"}, 64'(W), 64'(0));
        check({tag, "_total"}, 64'(total_count), 64'(0));
        check({tag, "_err"}, 64'(error_count), 64'(0));
        check({tag, "_lfw"}, 64'(last_fail_w), 64'(0));
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_done"}, 64'(done), 64'(0));
        check({tag, "_ready"}, 64'(pat_ready), 64'(0));
        check({tag, "_fail"}, 64'(fail_pulse), 64'(0));
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        exp_total = 0;
        exp_err   = 0;
        exp_tmo   = 0;
        check("start_busy", 64'(busy), 64'(1));
        check("start_done", 64'(done), 64'(0));
        check("start_total", 64'(total_count), 64'(0));
        check("start_err", 64'(error_count), 64'(0));
    endtask

    // One pattern transaction. Cycle 0 is the accept cycle; found is raised
    // from cycle k on (k<0: never), or held high throughout if stale.
    // The pattern is checked in the cycle the model predicts:
    //   found is honoured from cycle ARM_EFF+1, then SETTLE, then CHECK.
    task automatic do_pat(input logic [W_BITS-1:0] p, input bit last,
                          input logic [N_BITS-1:0] nval, input int k,
                          input bit stale, input bit late_n, input int stall);
        int ec;
        int fc;
        bit bad;
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (pat_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("ready_wait", 64'(ok), 64'(1));
        if (!ok) return;
        for (int i = 0; i < stall; i++) begin
            check("stall_ready", 64'(pat_ready), 64'(1));
            check("stall_busy", 64'(busy), 64'(1));
            check("stall_W", 64'(W), 64'(exp_w));
            @(negedge clk);
        end
        pat_valid = 1'b1;
        pat_data  = p;
        pat_last  = last;
        @(posedge clk);
        #1;
        pat_valid = 1'b0;
        pat_data  = W_BITS'($urandom);
        pat_last  = 1'b0;
        exp_w = p;

        if (!stale && k < 0) begin
            ec  = ARM_EFF + TIMEOUT;
            bad = 1'b1;
        end else begin
            fc  = stale ? 1 : k;
            if (fc < ARM_EFF + 1) fc = ARM_EFF + 1;
            ec  = fc + SET_EFF + 1;
            bad = (nval != N_BITS'(EXP_N));
        end

        for (int c = 1; c <= ec + 1; c++) begin
            found = stale || (k >= 0 && c >= k);
            N     = (late_n && c < ec) ? (nval ^ 31'h2AAA_AAAA) : nval;
            @(negedge clk);
            if (c <= ec) begin
                check("fail_pulse", 64'(fail_pulse), 64'(c == ec && bad));
                check("run_busy", 64'(busy), 64'(1));
                check("run_W", 64'(W), 64'(p));
                if (c == ARM_EFF) check("run_ready", 64'(pat_ready), 64'(0));
            end else begin
                exp_total++;
                if (bad) begin
                    exp_err++;
                    exp_lfw = p;
                    if (k < 0 && !stale) exp_tmo++;
                end
                check("total", 64'(total_count), 64'(exp_total));
                check("errors", 64'(error_count), 64'(exp_err));
                check("last_fail_w", 64'(last_fail_w), 64'(exp_lfw));
                check("end_done", 64'(done), 64'(last));
                check("end_busy", 64'(busy), 64'(!last));
                check("end_fail", 64'(fail_pulse), 64'(0));
`ifdef TRADEOFF_BIST_WATCHDOG_EN
                check("timeouts", 64'(timeout_count), 64'(exp_tmo));
`endif
            end
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [N_BITS-1:0] rand_n(input bit good);
        logic [N_BITS-1:0] v;
        v = N_BITS'(EXP_N);
        if (!good) v = v ^ (N_BITS'(1) << $urandom_range(N_BITS - 1, 0));
        return v;
    endfunction

    function automatic logic [W_BITS-1:0] rand_w();
        return {W_BITS'($urandom), 32'($urandom)} ;
    endfunction

    initial begin
        logic [W_BITS-1:0] p1, p2, p3;
        exp_w = '0; exp_lfw = '0; exp_total = 0; exp_err = 0; exp_tmo = 0;

        // Reset state.
        #12;
        check_idle_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("post_reset");

        // Three good patterns, found two cycles after ARM.
        do_start();
        p1 = rand_w(); p2 = rand_w(); p3 = rand_w();
        do_pat(p1, 1'b0, N_BITS'(EXP_N), ARM_EFF + 3, 1'b0, 1'b0, 0);
        do_pat(p2, 1'b0, N_BITS'(EXP_N), ARM_EFF + 3, 1'b0, 1'b0, 0);
        do_pat(p3, 1'b1, N_BITS'(EXP_N), ARM_EFF + 3, 1'b0, 1'b0, 0);
        repeat (3) @(negedge clk);
        check("done_held", 64'(done), 64'(1));

        // Pattern 2 returns EXP_N-1; pattern 3 stalled for 20 cycles in LOAD.
        do_start();
        p1 = rand_w(); p2 = rand_w(); p3 = rand_w();
        do_pat(p1, 1'b0, N_BITS'(EXP_N), ARM_EFF + 2, 1'b0, 1'b0, 0);
        do_pat(p2, 1'b0, N_BITS'(EXP_N - 1), ARM_EFF + 1, 1'b0, 1'b0, 0);
        do_pat(p3, 1'b1, N_BITS'(EXP_N), 1, 1'b0, 1'b0, 20);

        // Stale found held high through ARM, N settles only at CHECK.
        do_start();
        found = 1'b1;
        do_pat(rand_w(), 1'b0, N_BITS'(EXP_N), 0, 1'b1, 1'b1, 0);
        do_pat(rand_w(), 1'b0, rand_n(1'b0), 0, 1'b1, 1'b1, 0);
        do_pat(rand_w(), 1'b1, N_BITS'(EXP_N), 0, 1'b1, 1'b1, 2);
        found = 1'b0;

        // Asynchronous reset during WAIT_FOUND of pattern 2.
        do_start();
        do_pat(rand_w(), 1'b0, rand_n(1'b0), 4, 1'b0, 1'b0, 0);
        @(negedge clk);
        pat_valid = 1'b1;
        pat_data  = rand_w();
        @(posedge clk);
        #1;
        pat_valid = 1'b0;
        found = 1'b0;
        repeat (ARM_EFF + 2) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("async_reset");
        exp_w = '0; exp_lfw = '0;
        @(negedge clk);
        rst_n = 1'b1;
        do_start();
        do_pat(rand_w(), 1'b0, N_BITS'(EXP_N), 3, 1'b0, 1'b0, 0);
        do_pat(rand_w(), 1'b1, rand_n(1'b0), 6, 1'b0, 1'b0, 1);

        // Randomized run.
        do_start();
        for (int i = 0; i < 8; i++) begin
            do_pat(rand_w(), i == 7, rand_n($urandom_range(3, 0) != 0),
                   $urandom_range(9, 1), 1'b0, $urandom_range(1, 0) == 1,
                   $urandom_range(3, 0));
        end

`ifdef TRADEOFF_BIST_WATCHDOG_EN
        // Watchdog: found never rises on pattern 1, run continues.
        do_start();
        do_pat(rand_w(), 1'b0, N_BITS'(EXP_N), -1, 1'b0, 1'b0, 0);
        do_pat(rand_w(), 1'b1, N_BITS'(EXP_N), 4, 1'b0, 1'b0, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global time bound so the bench always terminates.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation time limit reached");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "time limit");
    end

endmodule

// File: doc/tradeoff_bist_driver.md
Name: tradeoff_bist_driver

Overview:
- Hardware self-test sequencer for the Tradeoff search core. It sits on the opposite side of the core's W/found/N interface.
- It accepts a stream of W patterns, drives each one onto the core and waits for `found`. It then compares the core's N against a fixed expected value and keeps pass/fail counters.
- Replaces file-driven stimulus for on-chip and FPGA regression of Tradeoff_30bits-class cores.

Parameters:
- W_BITS, 46, width of the W pattern driven to the core
- N_BITS, 31, width of the N result returned by the core
- EXP_N, 1073741813, expected N for every pattern
- ARM_CYCLES, 2, cycles after a new W during which `found` is ignored (the core's stale result)
- SETTLE_CYCLES, 1, cycles to wait after `found` rises before sampling N
- CNT_W, 16, width of the total and error counters

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; clears counters and begins a run (ignored unless IDLE or DONE)
- pat_valid  in  1  pattern available
- pat_data  in  W_BITS  pattern value
- pat_last  in  1  marks the final pattern of the run; qualified by pat_valid
- pat_ready  out  1  driver accepts pat_data this cycle
- W  out  W_BITS  pattern driven to the core; held stable until CHECK completes
- found  in  1  core completion flag
- N  in  N_BITS  core result
- busy  out  1  run in progress
- done  out  1  high from the end of a run until the next start
- fail_pulse  out  1  one-cycle pulse on each mismatch
- total_count  out  CNT_W  patterns checked
- error_count  out  CNT_W  mismatches
- last_fail_w  out  W_BITS  W of the most recent mismatch

Behaviour:
- Reset (asynchronous): state IDLE. W, counters and last_fail_w are 0; pat_ready, busy, done and fail_pulse are 0.
- IDLE / DONE:
  - start → counters cleared, done=0, busy=1, go to LOAD.
  - Outside IDLE and DONE, start is ignored.
- LOAD:
  - pat_ready=1.
  - When pat_valid: W←pat_data, store pat_last in last_flag, ARM counter ←ARM_CYCLES, go to ARM.
  - pat_ready is high only in LOAD (one beat per handshake). A pattern stream that stalls leaves the driver in LOAD indefinitely.
- ARM:
  - Decrement the counter; `found` is ignored.
  - At 0, go to WAIT_FOUND.
  - With ARM_CYCLES=0, go straight to WAIT_FOUND on the next cycle.
- WAIT_FOUND: when found==1, load the settle counter with SETTLE_CYCLES and go to SETTLE.
- SETTLE:
  - Decrement the counter; at 0, go to CHECK.
  - SETTLE_CYCLES=0 → CHECK on the next cycle.
- CHECK (one cycle):
  - total_count+1.
  - If N != EXP_N: error_count+1, last_fail_w←W, fail_pulse=1.
  - N is compared at the full N_BITS width, with EXP_N zero-extended.
  - Then: last_flag → DONE (busy=0, done=1); else → LOAD.
- Counter saturation: both counters saturate at all-ones; they never wrap.
- Latency: the minimum from pattern accept to CHECK is ARM_CYCLES+SETTLE_CYCLES+2 cycles, given found already high at the end of ARM.
- Reset mid-run: all state is discarded and the block returns to IDLE with outputs as above. No partial counts are retained.

Optional Feature:
- Macro: TRADEOFF_BIST_WATCHDOG_EN.
- When defined, adds:
  - parameter TIMEOUT_CYCLES (default 1048576);
  - output timeout_count (CNT_W).
- Watchdog behaviour when defined:
  - A counter runs while in WAIT_FOUND.
  - On reaching TIMEOUT_CYCLES, the current pattern is treated as failed: total_count+1, error_count+1, timeout_count+1, last_fail_w←W, fail_pulse=1.
  - Exit then follows the CHECK rules (LOAD, or DONE if last_flag).
  - timeout_count saturates, resets to 0 and is cleared on start.
- When undefined: no extra ports or parameters; WAIT_FOUND waits forever.

Test Plan:
- Three patterns (last on #3); the core model returns N=1073741813 with found two cycles after ARM → done=1, total_count=3, error_count=0, fail_pulse never high.
- Pattern 2 of 3 returns N=1073741812 → error_count=1, last_fail_w equals pattern 2, a single one-cycle fail_pulse, total_count=3.
- `found` held high from the previous pattern through ARM, with N changing late in SETTLE → the N sampled is the value present at CHECK, and stale `found` is not accepted during ARM.
- pat_valid withheld for 20 cycles in LOAD → W unchanged, busy=1, pat_ready=1 throughout; the run resumes on valid.
- rst_n asserted asynchronously during WAIT_FOUND of pattern 2 → all outputs 0 immediately; a new start runs cleanly from count 0.
- With TRADEOFF_BIST_WATCHDOG_EN and TIMEOUT_CYCLES=64, `found` never rises → timeout at cycle 64 of WAIT_FOUND, timeout_count=1, error_count=1, and the run continues to the next pattern.
